// File: rtl/rnn_mem_responder_if.sv
// rnn_mem_responder_if: host, accelerator and SRAM signal bundle for rnn_mem_responder.
// Defining RNN_WCOUNT_EN adds the wr_count signal to both modports.
interface rnn_mem_responder_if;
    logic        start;
    logic        x_valid;
    logic [31:0] x_data;
    logic        x_ready;
    logic        busy;
    logic        i_en;
    logic        mce;
    logic [2:0]  msel;
    logic [16:0] maddr;
    logic [19:0] mdata_w;
    logic        ready;
    logic [31:0] idata;
    logic [19:0] mdata_r;
    logic        sram_cs;
    logic        sram_we;
    logic [2:0]  sram_bank;
    logic [16:0] sram_addr;
    logic [19:0] sram_wdata;
    logic [19:0] sram_rdata;
    logic        done;
    logic        error;
`ifdef RNN_WCOUNT_EN
    logic [16:0] wr_count;
    modport slave (
        input  start, x_valid, x_data, busy, i_en, mce, msel, maddr, mdata_w, sram_rdata,
        output x_ready, ready, idata, mdata_r, sram_cs, sram_we, sram_bank, sram_addr,
               sram_wdata, done, error, wr_count
    );
    modport master (
        output start, x_valid, x_data, busy, i_en, mce, msel, maddr, mdata_w, sram_rdata,
        input  x_ready, ready, idata, mdata_r, sram_cs, sram_we, sram_bank, sram_addr,
               sram_wdata, done, error, wr_count
    );
`else
    modport slave (
        input  start, x_valid, x_data, busy, i_en, mce, msel, maddr, mdata_w, sram_rdata,
        output x_ready, ready, idata, mdata_r, sram_cs, sram_we, sram_bank, sram_addr,
               sram_wdata, done, error
    );
    modport master (
        output start, x_valid, x_data, busy, i_en, mce, msel, maddr, mdata_w, sram_rdata,
        input  x_ready, ready, idata, mdata_r, sram_cs, sram_we, sram_bank, sram_addr,
               sram_wdata, done, error
    );
`endif
endinterface

// File: rtl/rnn_mem_responder.sv
// rnn_mem_responder: host-side SRAM/input-vector responder and start handshake for the RNN accelerator.
// Optional RNN_WCOUNT_EN adds wr_count, a saturating count of SRAM writes in the current run.
module rnn_mem_responder #(
    parameter int FIFO_DEPTH    = 4,
    parameter int START_TIMEOUT = 16
) (
    input logic clk,
    input logic reset,
    rnn_mem_responder_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(START_TIMEOUT + 1);
    localparam logic [TW-1:0] TMAX = TW'(START_TIMEOUT);

    typedef enum logic [2:0] {S_IDLE, S_ARM, S_WAIT, S_RUN, S_DRAIN} state_t;

    state_t        state;
    logic [TW-1:0] timer;
    logic [31:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0]   cnt;
    logic [31:0]   idata_r;
    logic          ready_r, done_r, error_r;
    logic          full, empty, push, pop, h_wr, wr_en;

    // a full FIFO still takes a push when the same cycle pops
    always_comb begin
        full = cnt[AW];
        empty = cnt == '0;
        pop = bus.i_en & ~empty;
        push = bus.x_valid & (~full | pop);
        h_wr = bus.mce & (bus.msel == 3'b101);
        wr_en = h_wr & (state == S_RUN || state == S_DRAIN);
    end

    assign bus.x_ready    = ~full;
    assign bus.sram_cs    = bus.mce;
    assign bus.sram_bank  = bus.msel;
    assign bus.sram_addr  = bus.maddr;
    assign bus.sram_wdata = bus.mdata_w;
    assign bus.sram_we    = wr_en;
    assign bus.mdata_r    = (bus.mce & ~h_wr) ? bus.sram_rdata : '0;
    assign bus.ready      = ready_r;
    assign bus.done       = done_r;
    assign bus.error      = error_r;
    assign bus.idata      = idata_r;

    always_ff @(posedge clk)
        if (push) mem[wp] <= bus.x_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            timer <= '0;
            wp <= '0;
            rp <= '0;
            cnt <= '0;
            idata_r <= '0;
            ready_r <= 1'b0;
            done_r <= 1'b0;
            error_r <= 1'b0;
        end else begin
            ready_r <= 1'b0;
            done_r <= 1'b0;
            cnt <= cnt + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
            if (push) wp <= wp + 1'b1;
            if (pop) begin
                rp <= rp + 1'b1;
                idata_r <= mem[rp];
            end
            if (bus.i_en & empty) error_r <= 1'b1;
            case (state)
                S_IDLE: if (bus.start) begin
                    state <= S_ARM;
                    ready_r <= 1'b1;
                end else if (bus.busy) error_r <= 1'b1;
                S_ARM: begin
                    state <= S_WAIT;
                    timer <= '0;
                end
                S_WAIT: if (bus.busy) state <= S_RUN;
                else if (timer == TMAX) begin
                    error_r <= 1'b1;
                    state <= S_IDLE;
                end else timer <= timer + 1'b1;
                S_RUN: if (!bus.busy) begin
                    state <= S_DRAIN;
                    done_r <= 1'b1;
                end
                S_DRAIN: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef RNN_WCOUNT_EN
    logic [16:0] wcnt;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) wcnt <= '0;
        else if (state == S_IDLE && bus.start) wcnt <= '0;
        else if (wr_en && wcnt != '1) wcnt <= wcnt + 1'b1;
    end
    assign bus.wr_count = wcnt;
`endif
endmodule

// File: tb/tb_rnn_mem_responder.sv
// tb_rnn_mem_responder: directed and randomized checks of rnn_mem_responder against a queue-based model.
module tb_rnn_mem_responder;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int ncmp = 0;
    int nfail = 0;
    int nw = 0;
    logic [31:0] q[$];
    logic [31:0] exp_idata;
    logic exp_error;

    rnn_mem_responder_if b();
    rnn_mem_responder #(.FIFO_DEPTH(4), .START_TIMEOUT(16)) dut (.clk(clk), .reset(reset), .bus(b));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        q.delete();
        exp_idata = '0;
        exp_error = 1'b0;
    endtask

    // one clock of host stream / i_en traffic, modelled as a 4-deep queue
    task automatic fifo_cycle(input logic v, input logic [31:0] d, input logic ie);
        logic do_pop, do_push;
        b.x_valid = v;
        b.x_data = d;
        b.i_en = ie;
        #1 check("x_ready", b.x_ready, q.size() < 4);
        do_pop = ie && q.size() > 0;
        do_push = v && (q.size() < 4 || do_pop);
        if (ie && q.size() == 0) exp_error = 1'b1;
        if (do_pop) exp_idata = q.pop_front();
        if (do_push) q.push_back(d);
        tick;
        b.x_valid = 1'b0;
        b.i_en = 1'b0;
        check("idata", b.idata, exp_idata);
        check("error", b.error, exp_error);
    endtask

    task automatic mem_check(input string tag, input logic ce, input logic [2:0] sel, input logic [16:0] a,
                             input logic [19:0] w, input logic [19:0] r, input logic active);
        b.mce = ce;
        b.msel = sel;
        b.maddr = a;
        b.mdata_w = w;
        b.sram_rdata = r;
        #1;
        check({tag, "_cs"}, b.sram_cs, ce);
        check({tag, "_bank"}, b.sram_bank, sel);
        check({tag, "_addr"}, b.sram_addr, a);
        check({tag, "_wdata"}, b.sram_wdata, w);
        check({tag, "_we"}, b.sram_we, ce && sel == 3'd5 && active);
        check({tag, "_rdata"}, b.mdata_r, (ce && sel != 3'd5) ? r : 20'd0);
    endtask

    initial begin
        logic ce;
        logic [2:0] sel;
        b.start = 0; b.x_valid = 0; b.x_data = 0; b.busy = 0; b.i_en = 0;
        b.mce = 0; b.msel = 0; b.maddr = 0; b.mdata_w = 0; b.sram_rdata = 0;
        exp_idata = '0;
        exp_error = 1'b0;
        repeat (2) tick;
        check("rst_ready", b.ready, 0);
        check("rst_idata", b.idata, 0);
        check("rst_done", b.done, 0);
        check("rst_error", b.error, 0);
        check("rst_x_ready", b.x_ready, 1);
        reset = 1'b0;

        mem_check("rd", 1, 3'b010, 17'h0ABC, 20'h0, 20'h12345, 0);
        mem_check("wr_idle", 1, 3'b101, 17'h0083, 20'hFF000, 20'h55555, 0);
        for (int i = 0; i < 16; i++)
            mem_check("rnd_idle", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 17'($urandom),
                      20'($urandom), 20'($urandom), 0);
        b.mce = 0;
        tick;

        fifo_cycle(1, 32'hA5A5A5A5, 0);
        fifo_cycle(1, 32'h0000FFFF, 0);
        fifo_cycle(0, 0, 1);
        check("fifo_first", b.idata, 32'hA5A5A5A5);
        fifo_cycle(0, 0, 1);
        check("fifo_second", b.idata, 32'h0000FFFF);
        fifo_cycle(0, 0, 1);
        check("fifo_hold", b.idata, 32'h0000FFFF);
        check("fifo_underflow", b.error, 1);
        do_reset;

        for (int i = 0; i < 4; i++) fifo_cycle(1, 32'h10000000 + 32'(i), 0);
        check("full_x_ready", b.x_ready, 0);
        fifo_cycle(1, 32'hCAFE0004, 1);
        check("full_pushpop_x_ready", b.x_ready, 0);
        check("full_pop_head", b.idata, 32'h10000000);
        for (int i = 0; i < 4; i++) fifo_cycle(0, 0, 1);
        check("full_last", b.idata, 32'hCAFE0004);
        check("drained_x_ready", b.x_ready, 1);

        for (int i = 0; i < 60; i++)
            fifo_cycle(1'($urandom_range(0, 9) < 6), $urandom, 1'($urandom_range(0, 9) < 4));
        do_reset;

        // start handshake, busy rising 3 cycles after ready
        b.start = 1; tick; b.start = 1;
        check("hs_ready_arm", b.ready, 1);
        tick; b.start = 0;
        check("hs_ready_wait", b.ready, 0);
        tick;
        tick;
        b.busy = 1; tick;
        check("hs_ready_run", b.ready, 0);
        mem_check("wr_run", 1, 3'b101, 17'h0083, 20'hFF000, 20'h0, 1);
        nw = 1;
        b.start = 1; tick; b.start = 0;
        for (int i = 0; i < 10; i++) begin
            ce = 1'($urandom_range(0, 1));
            sel = ($urandom_range(0, 1) == 1) ? 3'b101 : 3'($urandom_range(0, 4));
            mem_check("rnd_run", ce, sel, 17'($urandom), 20'($urandom), 20'($urandom), 1);
            if (ce && sel == 3'b101) nw++;
            tick;
        end
        check("hs_start_in_run", b.ready, 0);
        mem_check("wr_lastbusy", 1, 3'b101, 17'h0100, 20'h0F0F0, 20'h0, 1);
        nw++;
        b.busy = 0; tick;
        check("hs_done", b.done, 1);
        mem_check("wr_drain", 1, 3'b101, 17'h0084, 20'h00ABC, 20'h0, 1);
        nw++;
        tick;
        check("hs_done_clear", b.done, 0);
        check("hs_ready_idle", b.ready, 0);
        check("hs_error", b.error, 0);
        mem_check("wr_after", 1, 3'b101, 17'h0083, 20'hFF000, 20'h0, 0);
`ifdef RNN_WCOUNT_EN
        check("wr_count", b.wr_count, 32'(nw));
`endif
        b.mce = 0;
        tick;
        check("hs_no_rearm", b.ready, 0);

        b.start = 1; tick; b.start = 0; tick;
        repeat (16) tick;
        check("to_not_yet", b.error, 0);
        tick;
        check("to_error", b.error, 1);
        b.start = 1; tick; b.start = 0;
        check("to_idle_rearm", b.ready, 1);
        do_reset;

        b.busy = 1; tick;
        check("spurious_busy", b.error, 1);
        b.busy = 0;
        do_reset;

        b.start = 1; tick; b.start = 0; tick;
        b.busy = 1; tick;
        for (int i = 0; i < 4; i++) fifo_cycle(1, $urandom | 32'h1, 0);
        fifo_cycle(0, 0, 1);
        reset = 1'b1;
        #1;
        check("mr_ready", b.ready, 0);
        check("mr_idata", b.idata, 0);
        check("mr_x_ready", b.x_ready, 1);
        check("mr_error", b.error, 0);
        check("mr_done", b.done, 0);
        tick;
        reset = 1'b0;
        b.busy = 0;
        q.delete();
        exp_idata = '0;
        exp_error = 1'b0;
        mem_check("mr_idle_we", 1, 3'b101, 17'h0001, 20'h00001, 20'h0, 0);
        b.mce = 0;
        fifo_cycle(0, 0, 1);
        check("mr_fifo_discarded", b.error, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
